// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and widths for the data-memory responder.
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam int WORD_W   = 32;
    localparam int BYTE_OFS = 2;
    localparam int CNT_W    = 4;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32 word storage, synchronous write, combinational read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);
    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;

    assign rdata = mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready word load/store responder with LATENCY wait states.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned or out-of-range requests on resp_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err
);
    localparam int AW = $clog2(DEPTH);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              lat_we;
    logic [AW-1:0]     lat_idx, c_idx;
    logic [WORD_W-1:0] lat_wdata, c_wdata, rd_data;
    logic              accept, commit, c_we, c_err;

    assign req_ready = state == IDLE;
    assign accept    = req_ready && req_valid;
    // With LATENCY==0 the commit happens on the accept edge, so use the live request.
    assign c_we      = req_ready ? req_we : lat_we;
    assign c_idx     = req_ready ? req_addr[AW+BYTE_OFS-1:BYTE_OFS] : lat_idx;
    assign c_wdata   = req_ready ? req_wdata : lat_wdata;

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (commit && c_we && !c_err),
        .addr  (c_idx),
        .wdata (c_wdata),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                state_nxt = LATENCY == 0 ? RESP : WAIT;
                commit    = LATENCY == 0;
            end
            WAIT: if (cnt == CNT_W'(1)) begin
                state_nxt = RESP;
                commit    = 1'b1;
            end
            RESP: if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_idx    <= '0;
            lat_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            if (accept) begin
                cnt       <= CNT_W'(LATENCY);
                lat_we    <= req_we;
                lat_idx   <= req_addr[AW+BYTE_OFS-1:BYTE_OFS];
                lat_wdata <= req_wdata;
            end else if (state == WAIT) cnt <= cnt - CNT_W'(1);
            if (commit) begin
                resp_valid <= 1'b1;
                resp_rdata <= (c_we || c_err) ? '0 : rd_data;
            end else if (state == RESP && resp_ready) resp_valid <= 1'b0;
        end

`ifdef DMEM_ALIGN_CHECK_EN
    logic lat_err, chk;
    assign chk   = |req_addr[BYTE_OFS-1:0] || req_addr >= WORD_W'(DEPTH * 4);
    assign c_err = req_ready ? chk : lat_err;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            lat_err  <= 1'b0;
            resp_err <= 1'b0;
        end else begin
            if (accept) lat_err <= chk;
            if (commit) resp_err <= c_err;
        end
`else
    logic unused_addr;
    assign unused_addr = &{1'b0, req_addr[WORD_W-1:AW+BYTE_OFS], req_addr[BYTE_OFS-1:0]};
    assign c_err       = 1'b0;
    assign resp_err    = 1'b0;
`endif
endmodule
